// File: rtl/rx_frame_buffer_pkg.sv
// Shared types and constants for the receive frame buffer.
// Holds the FSM encoding, default frame-length limits and the pointer-width helper.
package rx_frame_buffer_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned MIN_LEN_DEF = 60;
    localparam int unsigned MAX_LEN_DEF = 1518;

    // One-hot to match the downstream TX control stage
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RECV = 3'b010,
        DROP = 3'b100
    } state_t;

    // Pointer carries one extra wrap bit so full and empty are distinguishable
    function automatic int unsigned ptr_width(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

endpackage

// File: rtl/rx_frame_buffer_if.sv
// Byte-stream bus between the receive MAC, the frame buffer and the TX consumer.
// The slave modport is the buffer side; master is the MAC/consumer side.
interface rx_frame_buffer_if;
    import rx_frame_buffer_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_last;
    logic              rx_err;
    logic [BYTE_W-1:0] tx_data;
    logic              empty_buff;
    logic [LEN_W-1:0]  frm_len;
    logic              empty_len_buff;
    logic              nextByte;
    logic              nextLen;
    logic              rx_frame;
    logic [LEN_W-1:0]  drop_cnt;
    logic              overflow;

    modport slave (
        input  rx_data, rx_valid, rx_last, rx_err, nextByte, nextLen,
        output tx_data, empty_buff, frm_len, empty_len_buff, rx_frame, drop_cnt, overflow
    );

    modport master (
        output rx_data, rx_valid, rx_last, rx_err, nextByte, nextLen,
        input  tx_data, empty_buff, frm_len, empty_len_buff, rx_frame, drop_cnt, overflow
    );

endinterface

// File: rtl/rx_frame_buffer_sync_fifo_ptr.sv
// Generic FIFO pointer block with a separate commit pointer and a write rewind.
// Readers only see entries up to the commit pointer; rewind discards uncommitted writes.
module sync_fifo_ptr
    import rx_frame_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          commit,
    input  logic          rewind,
    input  logic          rd_en,
    output logic [PW-2:0] wr_addr,
    output logic [PW-2:0] rd_addr,
    output logic          full_c,
    output logic          empty_c
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] cmt_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_fire;

    assign empty_c = (rd_ptr == cmt_ptr);
    assign full_c  = ((wr_ptr - rd_ptr) == PW'(DEPTH));
    assign rd_fire = rd_en && !empty_c;
    assign wr_addr = wr_ptr[PW-2:0];
    assign rd_addr = rd_ptr[PW-2:0];

    // Commit includes a byte written in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            rd_ptr  <= '0;
        end else begin
            if (rewind) begin
                wr_ptr <= cmt_ptr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (commit) begin
                cmt_ptr <= wr_ptr + PW'(wr_en);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive buffer: writes MAC bytes, commits only good frames,
// and rewinds the write pointer to discard bad, runt, oversize or overflowing frames.
module rx_frame_buffer
    import rx_frame_buffer_pkg::*;
#(
    parameter int unsigned DATA_DEPTH = 4096,
    parameter int unsigned LEN_DEPTH  = 16,
    parameter int unsigned MIN_LEN    = MIN_LEN_DEF,
    parameter int unsigned MAX_LEN    = MAX_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    rx_frame_buffer_if.slave   bus
);

    localparam int unsigned DPW = ptr_width(DATA_DEPTH);
    localparam int unsigned LPW = ptr_width(LEN_DEPTH);

    logic [BYTE_W-1:0] mem  [DATA_DEPTH];
    logic [LEN_W-1:0]  lmem [LEN_DEPTH];

    logic [DPW-2:0] d_wr_addr, d_rd_addr;
    logic [LPW-2:0] l_wr_addr, l_rd_addr;
    logic           d_full_c, d_empty_c, l_full_c, l_empty_c;

    state_t         state, state_nx;
    logic [LEN_W-1:0] len, len_nx, final_len_c, drop_cnt_r;
    logic           err_seen, err_nx, final_err_c, good_c;
    logic           d_wr_c, d_cmt_c, d_rew_c, l_push_c, l_pop_c, drop_c, ovf_c;
    logic           next_len_q, rx_frame_r, overflow_r;

    sync_fifo_ptr #(.DEPTH(DATA_DEPTH)) u_data_ptr (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (d_wr_c),
        .commit  (d_cmt_c),
        .rewind  (d_rew_c),
        .rd_en   (bus.nextByte),
        .wr_addr (d_wr_addr),
        .rd_addr (d_rd_addr),
        .full_c  (d_full_c),
        .empty_c (d_empty_c)
    );

    sync_fifo_ptr #(.DEPTH(LEN_DEPTH)) u_len_ptr (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (l_push_c),
        .commit  (l_push_c),
        .rewind  (1'b0),
        .rd_en   (l_pop_c),
        .wr_addr (l_wr_addr),
        .rd_addr (l_rd_addr),
        .full_c  (l_full_c),
        .empty_c (l_empty_c)
    );

    assign l_pop_c     = bus.nextLen && !next_len_q;
    assign final_len_c = (state == IDLE) ? LEN_W'(1) : len + LEN_W'(1);
    assign final_err_c = ((state == IDLE) ? 1'b0 : err_seen) | bus.rx_err;
    assign good_c      = !final_err_c
                         && (final_len_c >= LEN_W'(MIN_LEN))
                         && (final_len_c <= LEN_W'(MAX_LEN));

    // Next-state and per-byte actions; the first byte in IDLE takes the same path as RECV
    always_comb begin
        state_nx = state;
        len_nx   = len;
        err_nx   = err_seen;
        d_wr_c   = 1'b0;
        d_cmt_c  = 1'b0;
        d_rew_c  = 1'b0;
        l_push_c = 1'b0;
        drop_c   = 1'b0;
        ovf_c    = 1'b0;
        unique case (state)
            IDLE, RECV: begin
                if (bus.rx_valid) begin
                    if (d_full_c ||
                        ((state == RECV) && (len == LEN_W'(MAX_LEN)) && !bus.rx_last)) begin
                        d_rew_c  = 1'b1;
                        drop_c   = 1'b1;
                        ovf_c    = d_full_c;
                        state_nx = bus.rx_last ? IDLE : DROP;
                    end else begin
                        d_wr_c   = 1'b1;
                        len_nx   = final_len_c;
                        err_nx   = final_err_c;
                        state_nx = RECV;
                        if (bus.rx_last) begin
                            state_nx = IDLE;
                            if (good_c && !l_full_c) begin
                                d_cmt_c  = 1'b1;
                                l_push_c = 1'b1;
                            end else begin
                                d_rew_c = 1'b1;
                                drop_c  = 1'b1;
                                ovf_c   = good_c && l_full_c;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (bus.rx_valid && bus.rx_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            len        <= '0;
            err_seen   <= 1'b0;
            next_len_q <= 1'b0;
            rx_frame_r <= 1'b0;
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            state      <= state_nx;
            len        <= len_nx;
            err_seen   <= err_nx;
            next_len_q <= bus.nextLen;
            rx_frame_r <= (state_nx != IDLE);
            overflow_r <= ovf_c;
            if (drop_c && (drop_cnt_r != '1)) begin
                drop_cnt_r <= drop_cnt_r + LEN_W'(1);
            end
        end
    end

    // Storage arrays carry no reset; contents are don't-care until committed
    always_ff @(posedge clk) begin
        if (d_wr_c) begin
            mem[d_wr_addr] <= bus.rx_data;
        end
        if (l_push_c) begin
            lmem[l_wr_addr] <= final_len_c;
        end
    end

    assign bus.tx_data        = mem[d_rd_addr];
    assign bus.empty_buff     = d_empty_c;
    assign bus.frm_len        = l_empty_c ? '0 : lmem[l_rd_addr];
    assign bus.empty_len_buff = l_empty_c;
    assign bus.rx_frame       = rx_frame_r;
    assign bus.drop_cnt       = drop_cnt_r;
    assign bus.overflow       = overflow_r;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Bench for rx_frame_buffer: a 4096-byte instance and a 128-byte/2-frame instance share
// one stimulus stream and are each compared every cycle against a queue-based model.
module tb_rx_frame_buffer;

    localparam int MIN_L = 60;
    localparam int MAX_L = 1518;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_d;
    logic       s_v, s_last, s_err, s_nb, s_nl;

    rx_frame_buffer_if bus_a ();
    rx_frame_buffer_if bus_b ();

    assign bus_a.rx_data  = s_d;
    assign bus_a.rx_valid = s_v;
    assign bus_a.rx_last  = s_last;
    assign bus_a.rx_err   = s_err;
    assign bus_a.nextByte = s_nb;
    assign bus_a.nextLen  = s_nl;
    assign bus_b.rx_data  = s_d;
    assign bus_b.rx_valid = s_v;
    assign bus_b.rx_last  = s_last;
    assign bus_b.rx_err   = s_err;
    assign bus_b.nextByte = s_nb;
    assign bus_b.nextLen  = s_nl;

    rx_frame_buffer u_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    rx_frame_buffer #(.DATA_DEPTH(128), .LEN_DEPTH(2)) u_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    always #5 clk = ~clk;

    // Reference model: committed bytes, pending bytes of the open frame, committed lengths
    logic [7:0] dq [2][$];
    logic [7:0] pq [2][$];
    int         lq [2][$];
    int         mmode [2];
    bit         merr [2];
    bit         mnl [2];
    int         mdrop [2];
    bit         movf [2];
    bit         ovf_seen [2];
    int         n_cmp = 0;
    int         n_err = 0;

    typedef struct {
        int n;
        int err_at;
        int exp_len;
        int exp_drop;
    } vec_t;
    vec_t tbl [13];

    function automatic int dd(int k);
        return (k == 0) ? 4096 : 128;
    endfunction

    function automatic int ld(int k);
        return (k == 0) ? 16 : 2;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset(int k);
        dq[k].delete();
        pq[k].delete();
        lq[k].delete();
        mmode[k] = 0;
        merr[k]  = 1'b0;
        mnl[k]   = 1'b0;
        mdrop[k] = 0;
        movf[k]  = 1'b0;
    endtask

    task automatic m_drop(int k);
        pq[k].delete();
        if (mdrop[k] < 65535) mdrop[k]++;
    endtask

    task automatic m_step(int k);
        bit dfull, lfull, good;
        int len;
        if (!rst) begin
            m_reset(k);
            return;
        end
        dfull   = (dq[k].size() + pq[k].size()) >= dd(k);
        lfull   = lq[k].size() >= ld(k);
        movf[k] = 1'b0;
        if (s_nb && dq[k].size() > 0) void'(dq[k].pop_front());
        if (s_nl && !mnl[k] && lq[k].size() > 0) void'(lq[k].pop_front());
        mnl[k] = s_nl;
        if (s_v) begin
            if (mmode[k] == 2) begin
                if (s_last) mmode[k] = 0;
            end else if (dfull || (pq[k].size() == MAX_L && !s_last)) begin
                m_drop(k);
                movf[k]  = dfull;
                mmode[k] = s_last ? 0 : 2;
            end else begin
                if (mmode[k] == 0) merr[k] = 1'b0;
                merr[k]  = merr[k] | s_err;
                pq[k].push_back(s_d);
                mmode[k] = 1;
                if (s_last) begin
                    len  = pq[k].size();
                    good = !merr[k] && len >= MIN_L && len <= MAX_L;
                    if (good && !lfull) begin
                        lq[k].push_back(len);
                        for (int j = 0; j < pq[k].size(); j++) dq[k].push_back(pq[k][j]);
                        pq[k].delete();
                    end else begin
                        movf[k] = good && lfull;
                        m_drop(k);
                    end
                    mmode[k] = 0;
                end
            end
        end
    endtask

    task automatic m_check(int k);
        logic [7:0]  td;
        logic [15:0] fl, dc;
        logic        eb, el, rf, ov;
        string       p;
        p  = (k == 0) ? "a" : "b";
        td = (k == 0) ? bus_a.tx_data        : bus_b.tx_data;
        eb = (k == 0) ? bus_a.empty_buff     : bus_b.empty_buff;
        fl = (k == 0) ? bus_a.frm_len        : bus_b.frm_len;
        el = (k == 0) ? bus_a.empty_len_buff : bus_b.empty_len_buff;
        rf = (k == 0) ? bus_a.rx_frame       : bus_b.rx_frame;
        dc = (k == 0) ? bus_a.drop_cnt       : bus_b.drop_cnt;
        ov = (k == 0) ? bus_a.overflow       : bus_b.overflow;
        chk({p, ".empty_buff"}, int'(eb), int'(dq[k].size() == 0));
        if (dq[k].size() > 0) chk({p, ".tx_data"}, int'(td), int'(dq[k][0]));
        chk({p, ".empty_len_buff"}, int'(el), int'(lq[k].size() == 0));
        chk({p, ".frm_len"}, int'(fl), (lq[k].size() > 0) ? lq[k][0] : 0);
        chk({p, ".rx_frame"}, int'(rf), int'(mmode[k] != 0));
        chk({p, ".drop_cnt"}, int'(dc), mdrop[k]);
        chk({p, ".overflow"}, int'(ov), int'(movf[k]));
    endtask

    task automatic cyc();
        @(posedge clk);
        m_step(0);
        m_step(1);
        #1;
        m_check(0);
        m_check(1);
        if (bus_a.overflow) ovf_seen[0] = 1'b1;
        if (bus_b.overflow) ovf_seen[1] = 1'b1;
    endtask

    task automatic rnd_pops();
        s_nb = 1'($urandom_range(0, 1));
        s_nl = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send_frame(int n, int err_at, bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_v = 1'b0; s_last = 1'b0; s_err = 1'b0;
                    rnd_pops();
                    cyc();
                end
                rnd_pops();
            end
            s_v    = 1'b1;
            s_d    = rnd ? 8'($urandom) : 8'(i);
            s_last = (i == n - 1);
            s_err  = (i == err_at);
            cyc();
        end
        s_v = 1'b0; s_last = 1'b0; s_err = 1'b0;
    endtask

    // Pops one length and n bytes from both instances, checking instance a's byte order
    task automatic drain_a(int n);
        for (int j = 0; j < n; j++) begin
            chk("drain.tx_data", int'(bus_a.tx_data), j & 255);
            s_nb = 1'b1;
            s_nl = (j == 0);
            cyc();
        end
        s_nb = 1'b0; s_nl = 1'b0;
        chk("drain.empty_buff", int'(bus_a.empty_buff), 1);
        chk("drain.empty_len_buff", int'(bus_a.empty_len_buff), 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        s_v = 1'b0; s_last = 1'b0; s_err = 1'b0; s_nb = 1'b0; s_nl = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    task automatic pop_all_b();
        s_nb = 1'b1;
        s_nl = 1'b1; cyc();
        s_nl = 1'b0; cyc();
        s_nl = 1'b1; cyc();
        s_nl = 1'b0;
        repeat (130) cyc();
        s_nb = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{64,   -1, 64,   0};
        tbl[1]  = '{100,  50, 0,    1};
        tbl[2]  = '{40,   -1, 0,    2};
        tbl[3]  = '{60,   -1, 60,   2};
        tbl[4]  = '{1519, -1, 0,    3};
        tbl[5]  = '{1530, -1, 0,    4};
        tbl[6]  = '{1518, -1, 1518, 4};
        tbl[7]  = '{59,   -1, 0,    5};
        tbl[8]  = '{61,   -1, 61,   5};
        tbl[9]  = '{1,    -1, 0,    6};
        tbl[10] = '{60,   0,  0,    7};
        tbl[11] = '{60,   59, 0,    8};
        tbl[12] = '{60,   -1, 60,   8};

        rst = 1'b0;
        s_d = '0; s_v = 1'b0; s_last = 1'b0; s_err = 1'b0; s_nb = 1'b0; s_nl = 1'b0;
        m_reset(0);
        m_reset(1);
        #2;
        chk("rst.empty_buff", int'(bus_a.empty_buff), 1);
        chk("rst.empty_len_buff", int'(bus_a.empty_len_buff), 1);
        chk("rst.frm_len", int'(bus_a.frm_len), 0);
        chk("rst.rx_frame", int'(bus_a.rx_frame), 0);
        chk("rst.overflow", int'(bus_a.overflow), 0);
        chk("rst.drop_cnt", int'(bus_b.drop_cnt), 0);
        cyc();
        rst = 1'b1;
        cyc();

        // Frame-level table on the large instance
        for (int t = 0; t < 13; t++) begin
            send_frame(tbl[t].n, tbl[t].err_at, 1'b0);
            chk($sformatf("tbl%0d.frm_len", t), int'(bus_a.frm_len), tbl[t].exp_len);
            chk($sformatf("tbl%0d.empty_len_buff", t), int'(bus_a.empty_len_buff), int'(tbl[t].exp_len == 0));
            chk($sformatf("tbl%0d.empty_buff", t), int'(bus_a.empty_buff), int'(tbl[t].exp_len == 0));
            chk($sformatf("tbl%0d.drop_cnt", t), int'(bus_a.drop_cnt), tbl[t].exp_drop);
            if (tbl[t].exp_len > 0) drain_a(tbl[t].exp_len);
        end

        // Data-full drop on the small instance, then recovery after draining
        do_reset();
        send_frame(60, -1, 1'b0);
        send_frame(60, -1, 1'b0);
        ovf_seen[1] = 1'b0;
        send_frame(60, -1, 1'b0);
        chk("dfull.overflow_seen", int'(ovf_seen[1]), 1);
        chk("dfull.drop_cnt", int'(bus_b.drop_cnt), 1);
        chk("dfull.frm_len", int'(bus_b.frm_len), 60);
        pop_all_b();
        chk("dfull.drained_empty", int'(bus_b.empty_buff), 1);
        chk("dfull.drained_len_empty", int'(bus_b.empty_len_buff), 1);
        send_frame(60, -1, 1'b0);
        chk("dfull.recover_frm_len", int'(bus_b.frm_len), 60);
        chk("dfull.recover_drop_cnt", int'(bus_b.drop_cnt), 1);

        // Length-FIFO-full drop: bytes drained but both length slots still occupied
        send_frame(60, -1, 1'b0);
        s_nb = 1'b1;
        repeat (130) cyc();
        s_nb = 1'b0;
        ovf_seen[1] = 1'b0;
        send_frame(60, -1, 1'b0);
        chk("lfull.overflow_seen", int'(ovf_seen[1]), 1);
        chk("lfull.drop_cnt", int'(bus_b.drop_cnt), 2);
        chk("lfull.empty_buff", int'(bus_b.empty_buff), 1);

        // Reset mid-frame with two frames committed and one drop counted
        do_reset();
        send_frame(10, -1, 1'b0);
        send_frame(60, -1, 1'b0);
        send_frame(60, -1, 1'b0);
        chk("mrst.pre_drop_cnt", int'(bus_a.drop_cnt), 1);
        chk("mrst.pre_frm_len", int'(bus_a.frm_len), 60);
        for (int i = 0; i < 20; i++) begin
            s_v = 1'b1; s_d = 8'(i);
            cyc();
        end
        s_v = 1'b0;
        rst = 1'b0;
        #1;
        chk("mrst.empty_buff", int'(bus_a.empty_buff), 1);
        chk("mrst.empty_len_buff", int'(bus_a.empty_len_buff), 1);
        chk("mrst.frm_len", int'(bus_a.frm_len), 0);
        chk("mrst.drop_cnt", int'(bus_a.drop_cnt), 0);
        chk("mrst.rx_frame", int'(bus_a.rx_frame), 0);
        cyc();
        rst = 1'b1;
        send_frame(60, -1, 1'b0);
        chk("mrst.after_frm_len", int'(bus_a.frm_len), 60);
        chk("mrst.after_drop_cnt", int'(bus_a.drop_cnt), 0);

        // Randomized frames, gaps, errors and pops against the model
        do_reset();
        for (int f = 0; f < 120; f++) begin
            int r, n, ea;
            r = int'($urandom_range(0, 9));
            if (r < 6)       n = int'($urandom_range(1, 130));
            else if (r < 8)  n = int'($urandom_range(55, 70));
            else if (r == 8) n = int'($urandom_range(1500, 1530));
            else             n = int'($urandom_range(1, 8));
            ea = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            send_frame(n, ea, 1'b1);
        end
        for (int i = 0; i < 50; i++) begin
            rnd_pops();
            cyc();
        end
        s_nb = 1'b0; s_nl = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
